ifu_fetch: RTL

//  Instruction fetch stage feeding the decoder (IDU). Owns the PC register, issues

---
 rtl/ifu_fetch_if.sv | 40 ++++
 rtl/ifu_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// port, and the instruction handshake towards decode.
interface ifu_fetch_if;
  // Redirect from branch/jump resolution
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // Instruction-memory request/response
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  // Decode handshake
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  // Sticky error
  logic        fetch_err;

  // Fetch unit side
  modport master (
    input  redirect_valid, redirect_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  inst_ready,
    output mem_req_valid, mem_req_addr,
    output inst_valid, inst, inst_pc,
    output fetch_err
  );

  // Environment side (memory, decode, branch resolution)
  modport slave (
    output redirect_valid, redirect_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output inst_ready,
    input  mem_req_valid, mem_req_addr,
    input  inst_valid, inst, inst_pc,
    input  fetch_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage. Owns the PC, issues one blocking word read at a
// time, and holds the fetched instruction for decode. Redirects kill stale
// fetches; a missing response or a misaligned redirect locks the stage in
// ERR until reset.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  logic [2:0]  state;
  logic [31:0] pc;
  logic        drop;      // response of the outstanding request is stale
  logic [7:0]  tcnt;
  logic [31:0] inst_r;
  logic [31:0] inst_pc_r;

  logic        misaligned;
  logic [7:0]  tcnt_inc;

  assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign tcnt_inc   = tcnt + 8'd1;

  // Outputs are decoded purely from registered state so decode and memory
  // never see a combinational path from their own inputs.
  assign bus.mem_req_valid = (state == S_REQ);
  assign bus.mem_req_addr  = pc;
  assign bus.inst_valid    = (state == S_HOLD);
  assign bus.inst          = inst_r;
  assign bus.inst_pc       = inst_pc_r;
  assign bus.fetch_err     = (state == S_ERR);

  // Fetch FSM, PC, kill flag, timeout counter and instruction holding register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values of its neighbours, so statement order does not matter.
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      tcnt      <= 8'd0;
      inst_r    <= 32'd0;
      inst_pc_r <= RESET_PC;
    end else if (state != S_ERR && misaligned) begin
      // Misaligned target is fatal; the PC keeps its last legal value.
      state <= S_ERR;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (bus.mem_req_ready) begin
            // A redirect on the accept cycle makes the in-flight read stale.
            state <= S_WAIT;
            tcnt  <= 8'd0;
            drop  <= bus.redirect_valid;
          end
        end

        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
            drop <= 1'b0;
            if (bus.redirect_valid) begin
              pc    <= bus.redirect_pc;
              state <= S_REQ;
            end else if (drop) begin
              state <= S_REQ;
            end else begin
              inst_r    <= bus.mem_rsp_data;
              inst_pc_r <= pc;
              state     <= S_HOLD;
            end
          end else begin
            tcnt <= tcnt_inc;
            if (bus.redirect_valid) begin
              pc   <= bus.redirect_pc;
              drop <= 1'b1;
            end
            if (tcnt_inc == TIMEOUT_L) state <= S_ERR;
          end
        end

        S_HOLD: begin
          // Redirect wins over consumption: the held instruction is wrong-path.
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= S_REQ;
          end else if (bus.inst_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end

        S_ERR:   state <= S_ERR;
        default: state <= S_ERR;
      endcase
    end
  end

endmodule
